// File: rtl/aes_fifo_block_bridge.sv
// Bridges the host<->CL word FIFO pair to an AES core: packs words into blocks and splits results back into words.
// Build option AES_BRIDGE_LOOPBACK_EN: bypass the core and echo assembled blocks straight to the out FIFO.
module aes_fifo_block_bridge #(
  parameter  int DATA_W        = 32,
  parameter  int WORDS_PER_BLK = 4,
  parameter  int CNT_W         = 16,
  localparam int BLK_W         = DATA_W * WORDS_PER_BLK
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n_sync,
  input  logic              in_empty,
  output logic              in_rd,
  input  logic [DATA_W-1:0] in_dout,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [BLK_W-1:0]  core_in_data,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [BLK_W-1:0]  core_out_data,
  input  logic              out_full,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_din,
  output logic [CNT_W-1:0]  blk_in_cnt,
  output logic [CNT_W-1:0]  blk_out_cnt
);

  localparam int IDX_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [2:0] {I_IDLE, I_REQ, I_WAIT, I_CAP, I_HOLD} ing_state_t;
  typedef enum logic {E_IDLE, E_PUSH} eg_state_t;

  ing_state_t        ing_state, ing_state_nxt;
  eg_state_t         eg_state, eg_state_nxt;
  logic [IDX_W-1:0]  k, k_nxt, j, j_nxt;
  logic              in_rd_nxt, core_in_valid_nxt, core_out_ready_nxt, out_wr_nxt;
  logic [BLK_W-1:0]  core_in_data_nxt, res_blk, res_blk_nxt, res_data;
  logic [DATA_W-1:0] out_din_nxt;
  logic [CNT_W-1:0]  blk_in_cnt_nxt, blk_out_cnt_nxt;
  logic              blk_xfer, res_xfer;

`ifdef AES_BRIDGE_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
  logic unused_core;
  assign unused_core = ^{core_in_ready, core_out_valid, core_out_data};
  // The held block moves straight into the egress latch once egress is idle.
  assign blk_xfer = (ing_state == I_HOLD) && (eg_state == E_IDLE);
  assign res_xfer = blk_xfer;
  assign res_data = core_in_data;
`else
  localparam bit LOOPBACK = 1'b0;
  assign blk_xfer = core_in_valid && core_in_ready;
  assign res_xfer = core_out_valid && core_out_ready;
  assign res_data = core_out_data;
`endif

  always_comb begin
    ing_state_nxt     = ing_state;
    in_rd_nxt         = 1'b0;
    core_in_valid_nxt = core_in_valid;
    core_in_data_nxt  = core_in_data;
    k_nxt             = k;
    blk_in_cnt_nxt    = blk_in_cnt;
    case (ing_state)
      I_IDLE: if (!in_empty) begin
        ing_state_nxt = I_REQ;
        in_rd_nxt     = 1'b1;
      end
      I_REQ: ing_state_nxt = I_WAIT;
      // FIFO read data is valid in the cycle after the pop was sampled.
      I_WAIT: begin
        ing_state_nxt = I_CAP;
        for (int w = 0; w < WORDS_PER_BLK; w++)
          if (k == IDX_W'(w)) core_in_data_nxt[BLK_W-1-w*DATA_W -: DATA_W] = in_dout;
      end
      I_CAP: if (k == LAST_IDX) begin
        ing_state_nxt     = I_HOLD;
        core_in_valid_nxt = !LOOPBACK;
      end else begin
        k_nxt = k + IDX_W'(1);
        if (!in_empty) begin
          ing_state_nxt = I_REQ;
          in_rd_nxt     = 1'b1;
        end else begin
          ing_state_nxt = I_IDLE;
        end
      end
      I_HOLD: if (blk_xfer) begin
        ing_state_nxt     = I_IDLE;
        core_in_valid_nxt = 1'b0;
        blk_in_cnt_nxt    = blk_in_cnt + CNT_W'(1);
        k_nxt             = '0;
      end
      default: ing_state_nxt = I_IDLE;
    endcase
  end

  always_comb begin
    eg_state_nxt       = eg_state;
    res_blk_nxt        = res_blk;
    j_nxt              = j;
    core_out_ready_nxt = core_out_ready;
    out_wr_nxt         = 1'b0;
    out_din_nxt        = out_din;
    blk_out_cnt_nxt    = blk_out_cnt;
    case (eg_state)
      E_IDLE: if (res_xfer) begin
        eg_state_nxt       = E_PUSH;
        res_blk_nxt        = res_data;
        core_out_ready_nxt = 1'b0;
        j_nxt              = '0;
      end else begin
        core_out_ready_nxt = !LOOPBACK;
      end
      // Words leave MSB-first; a full FIFO simply freezes the word index.
      E_PUSH: if (!out_full) begin
        out_wr_nxt = 1'b1;
        for (int w = 0; w < WORDS_PER_BLK; w++)
          if (j == IDX_W'(w)) out_din_nxt = res_blk[BLK_W-1-w*DATA_W -: DATA_W];
        if (j == LAST_IDX) begin
          eg_state_nxt       = E_IDLE;
          j_nxt              = '0;
          blk_out_cnt_nxt    = blk_out_cnt + CNT_W'(1);
          core_out_ready_nxt = !LOOPBACK;
        end else begin
          j_nxt = j + IDX_W'(1);
        end
      end
      default: eg_state_nxt = E_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      ing_state      <= I_IDLE;
      eg_state       <= E_IDLE;
      k              <= '0;
      j              <= '0;
      in_rd          <= 1'b0;
      core_in_valid  <= 1'b0;
      core_in_data   <= '0;
      core_out_ready <= 1'b0;
      res_blk        <= '0;
      out_wr         <= 1'b0;
      out_din        <= '0;
      blk_in_cnt     <= '0;
      blk_out_cnt    <= '0;
    end else begin
      ing_state      <= ing_state_nxt;
      eg_state       <= eg_state_nxt;
      k              <= k_nxt;
      j              <= j_nxt;
      in_rd          <= in_rd_nxt;
      core_in_valid  <= core_in_valid_nxt;
      core_in_data   <= core_in_data_nxt;
      core_out_ready <= core_out_ready_nxt;
      res_blk        <= res_blk_nxt;
      out_wr         <= out_wr_nxt;
      out_din        <= out_din_nxt;
      blk_in_cnt     <= blk_in_cnt_nxt;
      blk_out_cnt    <= blk_out_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_aes_fifo_block_bridge.sv
// Scoreboard bench for aes_fifo_block_bridge with behavioural models of both FIFOs and of the core handshake.
// Build with AES_BRIDGE_LOOPBACK_EN defined to exercise the loopback variant instead of the core path.
module tb_aes_fifo_block_bridge;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_empty = 1'b1;
  logic          in_rd;
  logic [31:0]   in_dout = '0;
  logic          core_in_valid, core_in_ready;
  logic [127:0]  core_in_data;
  logic          core_out_valid, core_out_ready;
  logic [127:0]  core_out_data;
  logic          out_full;
  logic          out_wr;
  logic [31:0]   out_din;
  logic [15:0]   blk_in_cnt, blk_out_cnt;

  int            totalChecks = 0;
  int            badChecks = 0;
  int            validCycles = 0;
  int            outWrCnt = 0;
  int            inRdViol = 0;
  int            fullViol = 0;
  logic          fullAtEdge = 1'b0;

  logic [31:0]   inQ[$];
  logic [127:0]  expBlkQ[$];
  logic [31:0]   expWordQ[$];
  logic [127:0]  partBlk = '0;
  int            partN = 0;

  aes_fifo_block_bridge dut (
    .clk_main_a0    (clk),
    .rst_main_n_sync(rst_n),
    .in_empty       (in_empty),
    .in_rd          (in_rd),
    .in_dout        (in_dout),
    .core_in_valid  (core_in_valid),
    .core_in_ready  (core_in_ready),
    .core_in_data   (core_in_data),
    .core_out_valid (core_out_valid),
    .core_out_ready (core_out_ready),
    .core_out_data  (core_out_data),
    .out_full       (out_full),
    .out_wr         (out_wr),
    .out_din        (out_din),
    .blk_in_cnt     (blk_in_cnt),
    .blk_out_cnt    (blk_out_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Host-to-user FIFO model: registered read data, empty flag updated on the clock.
  always @(posedge clk) begin
    if (in_rd && inQ.size() > 0) in_dout <= inQ.pop_front();
    in_empty   <= (inQ.size() == 0);
    fullAtEdge <= out_full;
  end

  // Scoreboard side: everything sampled on the falling edge, midway between DUT updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_in_valid) validCycles++;
      if (core_in_valid && core_in_ready) begin
        if (expBlkQ.size() == 0) checkOutput("blk_unexpected", 128'(expBlkQ.size()), 128'd1);
        else checkOutput("blk_data", core_in_data, expBlkQ.pop_front());
      end
      if (out_wr) begin
        outWrCnt++;
        if (expWordQ.size() == 0) checkOutput("word_unexpected", 128'(expWordQ.size()), 128'd1);
        else checkOutput("out_word", 128'(out_din), 128'(expWordQ.pop_front()));
      end
      if (in_rd && in_empty) inRdViol++;
      if (out_wr && fullAtEdge) fullViol++;
    end
  end

  task automatic applyStimulus(input logic [31:0] w);
    inQ.push_back(w);
`ifdef AES_BRIDGE_LOOPBACK_EN
    expWordQ.push_back(w);
`else
    partBlk[127-32*partN -: 32] = w;
    partN++;
    if (partN == 4) begin
      expBlkQ.push_back(partBlk);
      partN = 0;
    end
`endif
  endtask

  task automatic sendResult(input logic [127:0] blk);
    bit done = 0;
    core_out_data  = blk;
    core_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) expWordQ.push_back(blk[127-32*i -: 32]);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (core_out_ready) done = 1;
    end
    if (!done) checkOutput("result_hs_timeout", 128'(core_out_ready), 128'd1);
    @(posedge clk); #1;
    core_out_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (expBlkQ.size() == 0 && expWordQ.size() == 0) return;
    end
    checkOutput({tag, "_timeout"}, 128'(expBlkQ.size() + expWordQ.size()), 128'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_rd"}, 128'(in_rd), 128'd0);
    checkOutput({tag, "_out_wr"}, 128'(out_wr), 128'd0);
    checkOutput({tag, "_cin_valid"}, 128'(core_in_valid), 128'd0);
    checkOutput({tag, "_cout_ready"}, 128'(core_out_ready), 128'd0);
    checkOutput({tag, "_cin_data"}, core_in_data, 128'd0);
    checkOutput({tag, "_out_din"}, 128'(out_din), 128'd0);
    checkOutput({tag, "_blk_in_cnt"}, 128'(blk_in_cnt), 128'd0);
    checkOutput({tag, "_blk_out_cnt"}, 128'(blk_out_cnt), 128'd0);
  endtask

  initial begin
    int base, chg, rds;
    bit seen;
    logic [127:0] held;
    rst_n = 1'b0;
    core_in_ready = 1'b0;
    core_out_valid = 1'b0;
    core_out_data = '0;
    out_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkResetValues("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef AES_BRIDGE_LOOPBACK_EN
    for (int i = 0; i < 8; i++) applyStimulus(32'hA5000000 + 32'(i * 32'h01010101));
    waitDrain("loop");
    repeat (3) @(posedge clk); #1;
    checkOutput("loop_blk_in_cnt", 128'(blk_in_cnt), 128'd2);
    checkOutput("loop_blk_out_cnt", 128'(blk_out_cnt), 128'd2);
`else
    $display("[TB] ingest of one block");
    core_in_ready = 1'b1;
    base = validCycles;
    applyStimulus(32'h00112233);
    applyStimulus(32'h44556677);
    applyStimulus(32'h8899AABB);
    applyStimulus(32'hCCDDEEFF);
    waitDrain("blk1");
    repeat (2) @(posedge clk); #1;
    checkOutput("blk1_valid_cycles", 128'(validCycles - base), 128'd1);
    checkOutput("blk1_cnt", 128'(blk_in_cnt), 128'd1);

    $display("[TB] egress of one result");
    sendResult(128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A);
    waitDrain("res1");
    repeat (2) @(posedge clk); #1;
    checkOutput("res1_cnt", 128'(blk_out_cnt), 128'd1);

    $display("[TB] egress with out FIFO backpressure");
    sendResult(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
    base = outWrCnt;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      if (outWrCnt >= base + 2) seen = 1;
    end
    checkOutput("bp_two_words_seen", 128'(seen), 128'd1);
    #1 out_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_full = 1'b0;
    waitDrain("res2");
    repeat (2) @(posedge clk); #1;
    checkOutput("res2_cnt", 128'(blk_out_cnt), 128'd2);

    $display("[TB] core stalls ingest");
    core_in_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(32'h10000000 * 32'(i + 1) + 32'(i));
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (core_in_valid) seen = 1;
    end
    checkOutput("stall_valid_seen", 128'(seen), 128'd1);
    held = core_in_data;
    chg = 0;
    rds = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_in_data !== held) chg++;
      if (in_rd) rds++;
    end
    checkOutput("stall_data_changes", 128'(chg), 128'd0);
    checkOutput("stall_pops", 128'(rds), 128'd0);
    @(posedge clk); #1;
    core_in_ready = 1'b1;
    waitDrain("stall");
    repeat (2) @(posedge clk); #1;
    checkOutput("stall_cnt", 128'(blk_in_cnt), 128'd3);

    $display("[TB] reset mid-block");
    applyStimulus(32'hDEAD0001);
    applyStimulus(32'hDEAD0002);
    for (int i = 0; i < 50 && inQ.size() != 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    partN = 0;
    #1;
    checkOutput("midrst_cin_valid", 128'(core_in_valid), 128'd0);
    checkOutput("midrst_in_rd", 128'(in_rd), 128'd0);
    checkOutput("midrst_cin_data", core_in_data, 128'd0);
    checkOutput("midrst_blk_in_cnt", 128'(blk_in_cnt), 128'd0);
    checkOutput("midrst_blk_out_cnt", 128'(blk_out_cnt), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(32'hCAFE0000);
    applyStimulus(32'hCAFE1111);
    applyStimulus(32'hCAFE2222);
    applyStimulus(32'hCAFE3333);
    waitDrain("fresh");
    repeat (2) @(posedge clk); #1;
    checkOutput("fresh_cnt", 128'(blk_in_cnt), 128'd1);
`endif

    checkOutput("in_rd_while_empty", 128'(inRdViol), 128'd0);
    checkOutput("out_wr_while_full", 128'(fullViol), 128'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
